ls_port_arbiter: RTL and testbench

- Owns the single 128-bit local-store port and shares it between two requesters: odd-pipe load/store (LSU) quadword accesses and instruction-fetch line refills (1024-bit line = 8 beats).
- Sits between fetch, the odd pipe and local_store, replacing their direct connection.
- Sequences refill bursts, assembles lines, arbitrates with anti-starvation, and honours branch flush.

---
 rtl/ls_port_arbiter_pkg.sv | 22 ++
 rtl/ls_port_arbiter_if.sv | 44 ++++
 rtl/ls_line_assembler.sv | 67 ++++++
 rtl/ls_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ls_port_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ls_port_arbiter_pkg.sv
// Shared types and constants for the local-store port arbiter.
// Spec bit 0 is the MSB of every bus, so [0:N] fields are held here as [N:0].
package ls_port_arbiter_pkg;

  localparam int LINE_BITS = 1024;
  localparam int QW_BITS   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef logic [QW_BITS-1:0]   qw_t;
  typedef logic [LINE_BITS-1:0] line_t;

  // Local-store quadword address: wrap to the store size, drop the byte offset.
  function automatic logic [31:0] qw_addr(input logic [31:0] addr, input logic [31:0] ls_bytes);
    return addr & (ls_bytes - 32'd1) & 32'hFFFF_FFF0;
  endfunction

endpackage

// File: rtl/ls_port_arbiter_if.sv
// Bundle of LSU, fetch and local-store signals around the port arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface ls_port_arbiter_if;
  import ls_port_arbiter_pkg::*;

  logic        lsu_req;
  logic        lsu_wr;
  logic [31:0] lsu_addr;
  qw_t         lsu_wdata;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  qw_t         lsu_rdata;

  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt;
  line_t       ifu_line;
  logic        ifu_line_valid;
  logic        flush;

  logic [31:0] ls_addr;
  logic        ls_wr_en;
  qw_t         ls_data_wr;
  qw_t         ls_data_rd;

  modport slave (
    input  lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    input  ifu_req, ifu_addr, flush,
    output ifu_gnt, ifu_line, ifu_line_valid,
    output ls_addr, ls_wr_en, ls_data_wr,
    input  ls_data_rd
  );

  modport master (
    output lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    output ifu_req, ifu_addr, flush,
    input  ifu_gnt, ifu_line, ifu_line_valid,
    input  ls_addr, ls_wr_en, ls_data_wr,
    output ls_data_rd
  );

endinterface

// File: rtl/ls_line_assembler.sv
// Collects refill beats one cycle after issue into a line; line_valid pulses the cycle after the last beat lands.
// Flush kills the pending capture and the beat issued alongside it; the output line keeps its last complete value.
module ls_line_assembler
  import ls_port_arbiter_pkg::*;
#(
  parameter int BEATS = 8,
  parameter int IDX_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_issue,
  input  logic [IDX_W-1:0]           i_idx,
  input  logic                       i_flush,
  input  qw_t                        i_data,
  output logic [BEATS*QW_BITS-1:0]   o_line,
  output logic                       o_line_valid
);

  localparam int LINE_W = BEATS * QW_BITS;

  logic              r_pend;
  logic [IDX_W-1:0]  r_pend_idx;
  logic [LINE_W-1:0] r_asm;
  logic [LINE_W-1:0] r_line;
  logic              r_line_vld;

  logic              w_capture;
  logic              w_last;
  logic [LINE_W-1:0] w_asm_nxt;

  assign w_capture = r_pend & ~i_flush;
  assign w_last    = w_capture && (r_pend_idx == IDX_W'(BEATS - 1));

  // Beat k lands in the k-th quadword from the top of the line.
  always_comb begin
    w_asm_nxt = r_asm;
    for (int k = 0; k < BEATS; k++) begin
      if (r_pend_idx == IDX_W'(k)) begin
        w_asm_nxt[LINE_W-1-QW_BITS*k -: QW_BITS] = i_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
      r_asm      <= '0;
      r_line     <= '0;
      r_line_vld <= 1'b0;
    end else begin
      r_pend     <= i_issue & ~i_flush;
      r_pend_idx <= i_idx;
      r_line_vld <= w_last;
      if (w_capture) begin
        r_asm <= w_asm_nxt;
      end
      if (w_last) begin
        r_line <= w_asm_nxt;
      end
    end
  end

  assign o_line       = r_line;
  assign o_line_valid = r_line_vld;

endmodule

// File: rtl/ls_port_arbiter.sv
// Shares the 128-bit local-store port between single-cycle LSU accesses and BEATS-beat fetch refills.
// LSU is granted combinationally and waits during a burst; fetch wins after STARVE_LIMIT LSU grants.
module ls_port_arbiter
  import ls_port_arbiter_pkg::*;
#(
  parameter int BEATS        = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int LS_BYTES     = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  ls_port_arbiter_if.slave  bus
);

  localparam int                  BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0]         LS_SIZE    = 32'(LS_BYTES);
  localparam logic [31:0]         LINE_MASK  = ~(32'(BEATS * 16) - 32'd1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic [31:0]         r_base;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_rvalid;

  logic                w_ifu_ok;
  logic                w_lsu_win;
  logic                w_ifu_win;
  logic                w_issue;
  logic [BEAT_W-1:0]   w_issue_idx;
  logic [31:0]         w_issue_addr;
  logic [31:0]         w_line_base;
  logic [31:0]         w_beat_off;

  assign w_ifu_ok    = bus.ifu_req & ~bus.flush;
  assign w_line_base = qw_addr(bus.ifu_addr, LS_SIZE) & LINE_MASK;
  assign w_beat_off  = {{(32-BEAT_W-4){1'b0}}, r_beat, 4'b0000};

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = '0;
    w_lsu_win    = 1'b0;
    w_ifu_win    = 1'b0;
    w_issue      = 1'b0;
    w_issue_idx  = '0;
    w_issue_addr = '0;
    unique case (r_state)
      IDLE: begin
        if (w_ifu_ok && (!bus.lsu_req || r_starve_cnt == STARVE_MAX)) begin
          w_ifu_win    = 1'b1;
          w_issue      = 1'b1;
          w_issue_addr = w_line_base;
          w_beat_nxt   = BEAT_W'(1);
          w_state_nxt  = (BEATS > 1) ? BURST : DRAIN;
        end else if (bus.lsu_req) begin
          w_lsu_win = 1'b1;
        end
      end
      BURST: begin
        w_issue      = 1'b1;
        w_issue_idx  = r_beat;
        w_issue_addr = qw_addr(r_base + w_beat_off, LS_SIZE);
        if (bus.flush) begin
          w_state_nxt = IDLE;
        end else if (r_beat == LAST_BEAT) begin
          w_state_nxt = DRAIN;
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      // Last beat's data is on the bus this cycle but the address port is free.
      DRAIN: begin
        w_lsu_win   = bus.lsu_req;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Keep combinational outputs quiet while reset is asserted.
    if (!rst_n) begin
      w_lsu_win    = 1'b0;
      w_ifu_win    = 1'b0;
      w_issue      = 1'b0;
      w_issue_addr = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_base       <= '0;
      r_starve_cnt <= '0;
      r_rvalid     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_beat   <= w_beat_nxt;
      r_rvalid <= w_lsu_win & ~bus.lsu_wr;
      if (w_ifu_win) begin
        r_base <= w_line_base;
      end
      if (w_ifu_win) begin
        r_starve_cnt <= '0;
      end else if (w_lsu_win && bus.ifu_req && r_starve_cnt != STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign bus.lsu_gnt    = w_lsu_win;
  assign bus.ifu_gnt    = w_ifu_win;
  assign bus.ls_addr    = w_lsu_win ? qw_addr(bus.lsu_addr, LS_SIZE) : w_issue_addr;
  assign bus.ls_wr_en   = w_lsu_win & bus.lsu_wr;
  assign bus.ls_data_wr = w_lsu_win ? bus.lsu_wdata : '0;
  assign bus.lsu_rvalid = r_rvalid;
  assign bus.lsu_rdata  = r_rvalid ? bus.ls_data_rd : '0;

  ls_line_assembler #(
    .BEATS (BEATS),
    .IDX_W (BEAT_W)
  ) u_line_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_issue      (w_issue),
    .i_idx        (w_issue_idx),
    .i_flush      (bus.flush),
    .i_data       (bus.ls_data_rd),
    .o_line       (bus.ifu_line),
    .o_line_valid (bus.ifu_line_valid)
  );

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Directed bench for ls_port_arbiter: LSU access, refill bursts, starvation, flush and mid-burst reset.
module tb_ls_port_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] last_base;

  ls_port_arbiter_if b ();

  ls_port_arbiter #(
    .BEATS        (8),
    .STARVE_LIMIT (4),
    .LS_BYTES     (32768)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a, a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678};
  endfunction

  function automatic logic [127:0] beat(input logic [1023:0] line, input int k);
    return line[1023-128*k -: 128];
  endfunction

  // Local store model: read data one cycle after the address.
  always @(posedge clk) b.ls_data_rd <= pat(b.ls_addr);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fetch_line(input logic [31:0] req, input logic [31:0] base, input bit lsu_mid);
    b.ifu_req  = 1'b1;
    b.ifu_addr = req;
    @(negedge clk);
    chk("fetch_gnt", 128'(b.ifu_gnt), 128'd1);
    chk("beat0_addr", 128'(b.ls_addr), 128'(base));
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      b.ifu_req = 1'b0;
      if (lsu_mid && k == 5) begin
        b.lsu_req   = 1'b1;
        b.lsu_wr    = 1'b1;
        b.lsu_addr  = 32'h0000_0047;
        b.lsu_wdata = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
      end
      @(negedge clk);
      chk($sformatf("beat%0d_addr", k), 128'(b.ls_addr), 128'((base + 32'(16*k)) & 32'h0000_7FFF));
      chk("beat_wr_en", 128'(b.ls_wr_en), 128'd0);
      if (lsu_mid && k >= 5) chk("lsu_wait_burst", 128'(b.lsu_gnt), 128'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_lsu_gnt", 128'(b.lsu_gnt), 128'(lsu_mid));
    chk("drain_wr_en", 128'(b.ls_wr_en), 128'(lsu_mid));
    chk("drain_addr", 128'(b.ls_addr), lsu_mid ? 128'h40 : 128'h0);
    chk("drain_no_valid", 128'(b.ifu_line_valid), 128'd0);
    @(posedge clk); #1;
    b.lsu_req = 1'b0;
    b.lsu_wr  = 1'b0;
    @(negedge clk);
    chk("line_valid", 128'(b.ifu_line_valid), 128'd1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("line_beat%0d", k), beat(b.ifu_line, k), pat((base + 32'(16*k)) & 32'h0000_7FFF));
    chk("store_no_rvalid", 128'(b.lsu_rvalid), 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_one_pulse", 128'(b.ifu_line_valid), 128'd0);
    chk("line_held", beat(b.ifu_line, 0), pat(base));
    @(posedge clk); #1;
    last_base = base;
  endtask

  initial begin
    int waited;
    total = 0;
    bad   = 0;
    last_base = 32'h0;
    rst_n = 1'b0;
    b.lsu_req = 1'b0; b.lsu_wr = 1'b0; b.lsu_addr = '0; b.lsu_wdata = '0;
    b.ifu_req = 1'b0; b.ifu_addr = '0; b.flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_lsu_gnt", 128'(b.lsu_gnt), 128'd0);
    chk("rst_rvalid", 128'(b.lsu_rvalid), 128'd0);
    chk("rst_line_valid", 128'(b.ifu_line_valid), 128'd0);
    chk("rst_line", beat(b.ifu_line, 0), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ls_addr", 128'(b.ls_addr), 128'd0);
    chk("idle_data_wr", b.ls_data_wr, 128'd0);
    @(posedge clk); #1;

    // Back-to-back LSU loads, address wraps modulo 32 KiB
    b.lsu_req = 1'b1; b.lsu_wr = 1'b0; b.lsu_addr = 32'h0000_8010;
    @(negedge clk);
    chk("ld0_gnt", 128'(b.lsu_gnt), 128'd1);
    chk("ld0_addr", 128'(b.ls_addr), 128'h10);
    chk("ld0_wr_en", 128'(b.ls_wr_en), 128'd0);
    @(posedge clk); #1;
    b.lsu_addr = 32'h0000_1238;
    @(negedge clk);
    chk("ld1_gnt", 128'(b.lsu_gnt), 128'd1);
    chk("ld1_addr", 128'(b.ls_addr), 128'h1230);
    chk("ld0_rvalid", 128'(b.lsu_rvalid), 128'd1);
    chk("ld0_rdata", b.lsu_rdata, pat(32'h10));
    @(posedge clk); #1;
    b.lsu_req = 1'b0;
    @(negedge clk);
    chk("ld_idle_gnt", 128'(b.lsu_gnt), 128'd0);
    chk("ld1_rdata", b.lsu_rdata, pat(32'h1230));
    @(posedge clk); #1;
    b.lsu_req = 1'b1; b.lsu_wr = 1'b1; b.lsu_addr = 32'h0000_9055;
    b.lsu_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    @(negedge clk);
    chk("st_wr_en", 128'(b.ls_wr_en), 128'd1);
    chk("st_addr", 128'(b.ls_addr), 128'h1050);
    chk("st_data", b.ls_data_wr, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    @(posedge clk); #1;
    b.lsu_req = 1'b0; b.lsu_wr = 1'b0;
    @(negedge clk);
    chk("st_no_rvalid", 128'(b.lsu_rvalid), 128'd0);
    @(posedge clk); #1;

    // Refills: plain, LSU waiting through burst, top of store, out-of-range base
    fetch_line(32'h0000_0105, 32'h0000_0100, 1'b1);
    fetch_line(32'h0000_7F80, 32'h0000_7F80, 1'b0);
    fetch_line(32'h0000_7FF0, 32'h0000_7F80, 1'b0);
    fetch_line(32'h0001_0285, 32'h0000_0280, 1'b0);

    // Starvation: both held high, four LSU grants then fetch
    b.lsu_req = 1'b1; b.lsu_wr = 1'b0; b.lsu_addr = 32'h0000_0200;
    b.ifu_req = 1'b1; b.ifu_addr = 32'h0000_0300;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("starve_lsu%0d", c), 128'(b.lsu_gnt), 128'(c < 4));
      chk($sformatf("starve_ifu%0d", c), 128'(b.ifu_gnt), 128'(c == 4));
      @(posedge clk); #1;
    end
    b.lsu_req = 1'b0; b.ifu_req = 1'b0;
    @(negedge clk);
    chk("starve_cnt_clr", 128'(dut.r_starve_cnt), 128'd0);
    @(posedge clk); #1;
    waited = 0;
    while (b.ifu_line_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("starve_refill_done", 128'(b.ifu_line_valid), 128'd1);
    chk("starve_line", beat(b.ifu_line, 0), pat(32'h300));
    last_base = 32'h300;
    @(posedge clk); #1;

    // Flush at beat 3
    b.ifu_req = 1'b1; b.ifu_addr = 32'h0000_0400;
    @(negedge clk);
    chk("fl_gnt", 128'(b.ifu_gnt), 128'd1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      b.ifu_req = 1'b0;
      if (k == 3) b.flush = 1'b1;
      @(negedge clk);
      chk($sformatf("fl_beat%0d", k), 128'(b.ls_addr), 128'(32'h400 + 32'(16*k)));
    end
    @(posedge clk); #1;
    b.flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("fl_quiet_addr", 128'(b.ls_addr), 128'd0);
      chk("fl_no_valid", 128'(b.ifu_line_valid), 128'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("fl_line_kept%0d", k), beat(b.ifu_line, k), pat(last_base + 32'(16*k)));

    // Fetch request under flush ignored while LSU still granted
    b.ifu_req = 1'b1; b.ifu_addr = 32'h0000_0505; b.flush = 1'b1;
    b.lsu_req = 1'b1; b.lsu_wr = 1'b0; b.lsu_addr = 32'h0000_0020;
    @(negedge clk);
    chk("flreq_ifu_gnt", 128'(b.ifu_gnt), 128'd0);
    chk("flreq_lsu_gnt", 128'(b.lsu_gnt), 128'd1);
    chk("flreq_addr", 128'(b.ls_addr), 128'h20);
    @(posedge clk); #1;
    b.flush = 1'b0; b.lsu_req = 1'b0;
    fetch_line(32'h0000_0505, 32'h0000_0500, 1'b0);

    // Reset during beat 5
    b.ifu_req = 1'b1; b.ifu_addr = 32'h0000_0600;
    @(negedge clk);
    chk("rb_gnt", 128'(b.ifu_gnt), 128'd1);
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
      b.ifu_req = 1'b0;
      @(negedge clk);
    end
    chk("rb_beat5", 128'(b.ls_addr), 128'h650);
    #2;
    rst_n = 1'b0;
    b.lsu_req = 1'b1; b.lsu_wr = 1'b1; b.lsu_addr = 32'h0000_0070;
    b.lsu_wdata = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    #1;
    chk("rb_ls_addr", 128'(b.ls_addr), 128'd0);
    chk("rb_lsu_gnt", 128'(b.lsu_gnt), 128'd0);
    chk("rb_wr_en", 128'(b.ls_wr_en), 128'd0);
    chk("rb_data_wr", b.ls_data_wr, 128'd0);
    chk("rb_line", beat(b.ifu_line, 0), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rb_st_gnt", 128'(b.lsu_gnt), 128'd1);
    chk("rb_st_wr_en", 128'(b.ls_wr_en), 128'd1);
    chk("rb_st_addr", 128'(b.ls_addr), 128'h70);
    chk("rb_st_data", b.ls_data_wr, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);
    @(posedge clk); #1;
    b.lsu_req = 1'b0; b.lsu_wr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rb_no_valid", 128'(b.ifu_line_valid), 128'd0);
      chk("rb_quiet_addr", 128'(b.ls_addr), 128'd0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
